// File: rtl/up_down_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : up_down_ctrl_pkg
// Description : Shared types and defaults for the up/down counter control
//               front-end: run/stop FSM state encoding, default timing
//               parameters and a counter-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package up_down_ctrl_pkg;

    // Board-rate defaults: one count per second at 50 MHz, 20 ms debounce.
    localparam int DEF_TICK_DIV  = 50_000_000;
    localparam int DEF_DB_CYCLES = 1_000_000;

    typedef enum logic [1:0] {
        ST_STOP   = 2'd0,
        ST_RUN_UP = 2'd1,
        ST_RUN_DN = 2'd2
    } state_t;

    // Width of a counter that must hold 0..n-1. Never narrower than one bit
    // so that n = 1 (single-cycle debounce) still yields a legal vector.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Single pushbutton input path: 2-FF synchroniser, stability
//               debouncer and rising-edge press detector.
// Revision    : 1.0 - initial release
//
// Ports
//   CLK     in  clock, rising edge
//   RST     in  synchronous active-high reset
//   btn_raw in  raw asynchronous button, active high
//   level   out debounced button level
//   press   out one-cycle pulse on each 0->1 edge of the debounced level
// ============================================================================
module btn_debounce
    import up_down_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic CLK,
    input  logic RST,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int            CW       = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [1:0]    prime;
    logic          armed;
    logic          level_d;
    logic [CW-1:0] stab_cnt;

    // prime marks when sync2 holds a genuinely sampled value rather than its
    // reset value. The press detector is armed only after a real released
    // sample has been seen, so a button held through reset cannot produce a
    // press until it is let go and pressed again.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            prime    <= 2'b00;
            armed    <= 1'b0;
            level    <= 1'b0;
            level_d  <= 1'b0;
            stab_cnt <= '0;
        end else begin
            sync1   <= btn_raw;
            sync2   <= sync1;
            prime   <= {prime[0], 1'b1};
            level_d <= level;

            if (prime[1] && !sync2) begin
                armed <= 1'b1;
            end

            // Level follows sync2 only after DB_CYCLES consecutive cycles of
            // disagreement; any agreeing cycle restarts the count.
            if (sync2 != level) begin
                if (stab_cnt == CNT_LAST) begin
                    level    <= sync2;
                    stab_cnt <= '0;
                end else begin
                    stab_cnt <= stab_cnt + CW'(1);
                end
            end else begin
                stab_cnt <= '0;
            end
        end
    end

    assign press = level & ~level_d & armed;

endmodule
`default_nettype wire

// File: rtl/up_down_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : up_down_ctrl
// Description : Control front-end for the 4-bit up/down counter. Debounces
//               three pushbuttons, runs a STOP/RUN_UP/RUN_DN state machine
//               and divides the clock down to a one-cycle count strobe.
// Revision    : 1.0 - initial release
//
// Ports
//   CLK      in  sole clock, rising edge
//   RST      in  synchronous active-high reset
//   BTN_UP   in  raw button: run upwards
//   BTN_DN   in  raw button: run downwards
//   BTN_HOLD in  raw button: stop / resume last direction
//   UP       out registered count direction, 1 = up
//   TICK     out registered one-cycle count-enable strobe
//   RUN      out registered, high while counting
// ============================================================================
module up_down_ctrl
    import up_down_ctrl_pkg::*;
#(
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN_UP,
    input  logic BTN_DN,
    input  logic BTN_HOLD,
    output logic UP,
    output logic TICK,
    output logic RUN
);

    localparam int            TW       = cnt_width(TICK_DIV);
    localparam logic [TW-1:0] DIV_LAST = TW'(TICK_DIV - 1);

    logic          press_up;
    logic          press_dn;
    logic          press_hold;
    logic [2:0]    unused_level;

    state_t        state;
    state_t        state_nx;
    logic          last_up;
    logic          last_up_nx;
    logic [TW-1:0] div_cnt;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
        .CLK     (CLK),
        .RST     (RST),
        .btn_raw (BTN_UP),
        .level   (unused_level[0]),
        .press   (press_up)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dn (
        .CLK     (CLK),
        .RST     (RST),
        .btn_raw (BTN_DN),
        .level   (unused_level[1]),
        .press   (press_dn)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_hold (
        .CLK     (CLK),
        .RST     (RST),
        .btn_raw (BTN_HOLD),
        .level   (unused_level[2]),
        .press   (press_hold)
    );

    // HOLD outranks direction buttons; UP and DN together cancel out.
    always_comb begin
        state_nx   = state;
        last_up_nx = last_up;
        if (press_hold) begin
            if (state == ST_STOP) begin
                state_nx = last_up ? ST_RUN_UP : ST_RUN_DN;
            end else begin
                state_nx = ST_STOP;
            end
        end else if (press_up && !press_dn) begin
            state_nx   = ST_RUN_UP;
            last_up_nx = 1'b1;
        end else if (press_dn && !press_up) begin
            state_nx   = ST_RUN_DN;
            last_up_nx = 1'b0;
        end
    end

    // Outputs are registered from the next-state so they move on the same
    // edge as the state. The divider restarts on every state change and the
    // strobe is forced low on that edge, so a direction change and a TICK
    // never reach the counter together.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= ST_STOP;
            last_up <= 1'b1;
            div_cnt <= '0;
            UP      <= 1'b1;
            RUN     <= 1'b0;
            TICK    <= 1'b0;
        end else begin
            state   <= state_nx;
            last_up <= last_up_nx;
            UP      <= (state_nx == ST_RUN_UP) ||
                       ((state_nx == ST_STOP) && last_up_nx);
            RUN     <= (state_nx != ST_STOP);

            if ((state_nx != state) || (state_nx == ST_STOP)) begin
                div_cnt <= '0;
                TICK    <= 1'b0;
            end else if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                TICK    <= 1'b1;
            end else begin
                div_cnt <= div_cnt + TW'(1);
                TICK    <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_up_down_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_up_down_ctrl
// Description : Self-checking bench for up_down_ctrl with TICK_DIV=4 and
//               DB_CYCLES=3. A cycle-level reference model derived from the
//               button history is compared against every output on every
//               cycle, and directed scenarios pin hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_up_down_ctrl;

    localparam int TD = 4;
    localparam int DB = 3;
    localparam int HN = 4096;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic b_up   = 1'b0;
    logic b_dn   = 1'b0;
    logic b_hold = 1'b0;
    logic up;
    logic tick;
    logic run;

    up_down_ctrl #(.TICK_DIV(TD), .DB_CYCLES(DB)) dut (
        .CLK      (clk),
        .RST      (rst),
        .BTN_UP   (b_up),
        .BTN_DN   (b_dn),
        .BTN_HOLD (b_hold),
        .UP       (up),
        .TICK     (tick),
        .RUN      (run)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    bit checking    = 1'b0;

    task automatic check(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: actual=%b required=%b", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s @%0t: actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Button samples are kept per clock edge. The synchronised value seen at
    // edge k is the raw sample from edge k-2; anything at or before the last
    // reset edge reads as 0. A debounced level flips when the DB samples
    // feeding the last DB edges all disagree with it.
    int edge_n   = 0;
    int rst_edge = 0;
    int chg_edge = 0;
    bit hist [3][HN];
    bit dlev  [3];
    bit armed [3];
    bit pend  [3];
    int mstate = 0;          // 0 = stopped, 1 = running up, 2 = running down
    bit m_last_up = 1'b1;
    bit m_up   = 1'b1;
    bit m_run  = 1'b0;
    bit m_tick = 1'b0;

    function automatic bit seen(input int b, input int k);
        return (k <= rst_edge) ? 1'b0 : hist[b][k % HN];
    endfunction

    always @(posedge clk) begin
        bit raw [3];
        int nst;
        bit flip;
        edge_n++;
        raw[0] = b_up;
        raw[1] = b_dn;
        raw[2] = b_hold;
        if (rst) begin
            mstate    = 0;
            m_last_up = 1'b1;
            m_tick    = 1'b0;
            rst_edge  = edge_n;
            chg_edge  = edge_n;
            for (int b = 0; b < 3; b++) begin
                dlev[b]  = 1'b0;
                armed[b] = 1'b0;
                pend[b]  = 1'b0;
            end
        end else begin
            nst = mstate;
            if (pend[2]) begin
                nst = (mstate == 0) ? (m_last_up ? 1 : 2) : 0;
            end else if (pend[0] && !pend[1]) begin
                nst = 1;
                m_last_up = 1'b1;
            end else if (pend[1] && !pend[0]) begin
                nst = 2;
                m_last_up = 1'b0;
            end
            if (nst != mstate) begin
                chg_edge = edge_n;
                m_tick   = 1'b0;
            end else begin
                m_tick = (nst != 0) && (((edge_n - chg_edge) % TD) == 0);
            end
            mstate = nst;

            for (int b = 0; b < 3; b++) begin
                pend[b] = 1'b0;
                if ((edge_n - 2 > rst_edge) && !seen(b, edge_n - 2)) begin
                    armed[b] = 1'b1;
                end
                flip = 1'b1;
                for (int j = 2; j <= DB + 1; j++) begin
                    if (seen(b, edge_n - j) == dlev[b]) flip = 1'b0;
                end
                if (flip) begin
                    dlev[b] = ~dlev[b];
                    pend[b] = dlev[b] & armed[b];
                end
            end
        end
        for (int b = 0; b < 3; b++) hist[b][edge_n % HN] = raw[b];
        m_up  = (mstate == 1) || ((mstate == 0) && m_last_up);
        m_run = (mstate != 0);
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (checking) begin
            check("model_UP",   up,   m_up);
            check("model_RUN",  run,  m_run);
            check("model_TICK", tick, m_tick);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    int nticks;

    initial begin
        // 1. Reset and idle
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        checking = 1'b1;
        check("rst_UP", up, 1'b1);
        check("rst_RUN", run, 1'b0);
        check("rst_TICK", tick, 1'b0);
        nticks = 0;
        for (int i = 0; i < 20; i++) begin
            cycles(1);
            if (tick) nticks++;
        end
        check_int("idle_ticks", nticks, 0);

        // 2. Clean UP press: RUN on the 6th edge, ticks every 4 thereafter
        b_up = 1'b1;
        cycles(5);
        check("up_run_not_yet", run, 1'b0);
        cycles(1);
        check("up_run_rise", run, 1'b1);
        check("up_dir", up, 1'b1);
        for (int i = 1; i <= 12; i++) begin
            cycles(1);
            check("up_tick_pattern", tick, (i % 4) == 0);
            check("up_dir_hold", up, 1'b1);
        end
        b_up = 1'b0;
        cycles(8);

        // 3. Bouncing DN is rejected, then a steady DN press is taken.
        //    The direction change lands on a divider wrap edge.
        for (int i = 0; i < 10; i++) begin
            b_dn = (i % 2) == 0;
            cycles(1);
            check("bounce_run", run, 1'b1);
            check("bounce_up", up, 1'b1);
        end
        b_dn = 1'b0;
        cycles(4);
        b_dn = 1'b1;
        cycles(5);
        check("dn_up_before", up, 1'b1);
        cycles(1);
        check("dn_up_after", up, 1'b0);
        check("dn_run", run, 1'b1);
        check("dn_change_no_tick", tick, 1'b0);
        b_dn = 1'b0;
        cycles(8);

        // 4. HOLD stops with direction retained, HOLD again resumes down
        b_hold = 1'b1;
        cycles(6);
        check("hold_stop_run", run, 1'b0);
        check("hold_stop_up", up, 1'b0);
        b_hold = 1'b0;
        nticks = 0;
        for (int i = 0; i < 10; i++) begin
            cycles(1);
            if (tick) nticks++;
        end
        check_int("stop_ticks", nticks, 0);
        b_hold = 1'b1;
        cycles(6);
        check("resume_run", run, 1'b1);
        check("resume_up", up, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            cycles(1);
            check("resume_tick", tick, i == 4);
        end
        b_hold = 1'b0;
        cycles(8);

        // 5. Simultaneous buttons from STOP
        b_hold = 1'b1;
        cycles(6);
        check("stop_again", run, 1'b0);
        b_hold = 1'b0;
        cycles(8);
        b_up = 1'b1;
        b_dn = 1'b1;
        cycles(10);
        check("updn_run", run, 1'b0);
        check("updn_up", up, 1'b0);
        b_up = 1'b0;
        b_dn = 1'b0;
        cycles(8);
        b_up   = 1'b1;
        b_dn   = 1'b1;
        b_hold = 1'b1;
        cycles(6);
        check("all3_run", run, 1'b1);
        check("all3_up", up, 1'b0);
        b_up   = 1'b0;
        b_dn   = 1'b0;
        b_hold = 1'b0;
        cycles(8);

        // 6. Reset mid-run with UP held
        b_up = 1'b1;
        cycles(6);
        check("rr_run", run, 1'b1);
        check("rr_up", up, 1'b1);
        cycles(3);
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        check("rr_rst_UP", up, 1'b1);
        check("rr_rst_RUN", run, 1'b0);
        check("rr_rst_TICK", tick, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycles(1);
            check("rr_held_no_event", run, 1'b0);
        end
        b_up = 1'b0;
        cycles(8);
        b_up = 1'b1;
        cycles(5);
        check("rr_repress_early", run, 1'b0);
        cycles(1);
        check("rr_repress_run", run, 1'b1);
        check("rr_repress_up", up, 1'b1);
        b_up = 1'b0;
        cycles(4);

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
